// File: rtl/avalon_mm_sdram_pkg.sv
// Shared types and timing constants for the on-chip-RAM Avalon-MM SDRAM stand-in.
package avalon_mm_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   // Edges from read-command accept to the first readdata_val beat.
   localparam int RD_LATENCY = 2;

endpackage

// File: rtl/avalon_mm_be_ram.sv
// Simple dual-port RAM, per-byte write enable, registered read data one cycle after raddr.
// No reset on storage or read register; contents survive rst_n.
module avalon_mm_be_ram #(
   parameter int DATA_WIDTH     = 64,
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                        clk_i,
   input  logic                        we_i,
   input  logic [DATA_WIDTH/8-1:0]     be_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]       rdata_o
);

   localparam int NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [2**MEM_ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_mm_sdram_slave_ram.sv
// Avalon-MM burst slave backed by on-chip RAM; read beats arrive RD_LATENCY edges after accept.
// Stalls (wait_request) while issuing read beats and on simultaneous read+write in IDLE.
module avalon_mm_sdram_slave_ram
   import avalon_mm_sdram_pkg::*;
#(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 64,
   parameter int BURST_COUNT_WIDTH = 8,
   parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH/8,
   parameter int MEM_ADDR_WIDTH    = 10
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [ADDR_WIDTH-1:0]        address_i,
   input  logic [BURST_COUNT_WIDTH-1:0] burst_count_i,
   input  logic [DATA_WIDTH-1:0]        write_data_i,
   input  logic [BYTE_ENABLE_WIDTH-1:0] byte_enable_i,
   input  logic                         write_i,
   input  logic                         read_i,
   output logic                         wait_request_o,
   output logic [DATA_WIDTH-1:0]        read_data_o,
   output logic                         readdata_val_o,
   output logic                         proto_err_o
);

   localparam logic [BURST_COUNT_WIDTH-1:0] ONE = BURST_COUNT_WIDTH'(1);

   state_t                      state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [BURST_COUNT_WIDTH-1:0] rem_q, rem_d;
   logic                        perr_q, perr_d;
   logic                        init_q;
   logic [RD_LATENCY-1:0]       vld_pipe_q;
   logic [DATA_WIDTH-1:0]       rdata_q;

   logic [MEM_ADDR_WIDTH-1:0]   cmd_idx;
   logic                        bc_zero;
   logic [BURST_COUNT_WIDTH-1:0] bc_eff;
   logic                        wait_req;
   logic                        ram_we;
   logic [MEM_ADDR_WIDTH-1:0]   ram_waddr;
   logic [DATA_WIDTH-1:0]       ram_rdata;
   logic                        rd_issue;

   assign cmd_idx = address_i[MEM_ADDR_WIDTH-1:0];
   assign bc_zero = (burst_count_i == '0);
   assign bc_eff  = bc_zero ? ONE : burst_count_i;

   // Upper address bits alias onto the RAM; they are intentionally dropped.
   generate
      if (ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^address_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rem_d     = rem_q;
      perr_d    = perr_q;
      wait_req  = 1'b1;
      ram_we    = 1'b0;
      ram_waddr = idx_q;
      rd_issue  = 1'b0;
      if (init_q) begin
         case (state_q)
            IDLE: begin
               wait_req = 1'b0;
               if (read_i && write_i) begin
                  wait_req = 1'b1;
                  perr_d   = 1'b1;
               end else if (write_i) begin
                  ram_we    = 1'b1;
                  ram_waddr = cmd_idx;
                  idx_d     = cmd_idx + 1'b1;
                  rem_d     = bc_eff - 1'b1;
                  perr_d    = perr_q | bc_zero;
                  state_d   = (bc_eff == ONE) ? IDLE : WR;
               end else if (read_i) begin
                  idx_d   = cmd_idx;
                  rem_d   = bc_eff;
                  perr_d  = perr_q | bc_zero;
                  state_d = RD;
               end
            end
            WR: begin
               wait_req = 1'b0;
               perr_d   = perr_q | read_i;
               if (write_i) begin
                  ram_we  = 1'b1;
                  idx_d   = idx_q + 1'b1;
                  rem_d   = rem_q - 1'b1;
                  state_d = (rem_q == ONE) ? IDLE : WR;
               end
            end
            RD: begin
               rd_issue = 1'b1;
               idx_d    = idx_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               state_d  = (rem_q == ONE) ? IDLE : RD;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rem_q      <= '0;
         perr_q     <= 1'b0;
         init_q     <= 1'b0;
         vld_pipe_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         perr_q     <= perr_d;
         init_q     <= 1'b1;
         vld_pipe_q <= {vld_pipe_q[RD_LATENCY-2:0], rd_issue};
         // Output register only loads on real beats so read_data holds otherwise.
         if (vld_pipe_q[RD_LATENCY-2]) begin
            rdata_q <= ram_rdata;
         end
      end
   end

   avalon_mm_be_ram #(
      .DATA_WIDTH     (DATA_WIDTH),
      .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .be_i    (byte_enable_i),
      .waddr_i (ram_waddr),
      .wdata_i (write_data_i),
      .raddr_i (idx_q),
      .rdata_o (ram_rdata)
   );

   assign wait_request_o = wait_req;
   assign read_data_o    = rdata_q;
   assign readdata_val_o = vld_pipe_q[RD_LATENCY-1];
   assign proto_err_o    = perr_q;

endmodule

// File: doc/avalon_mm_sdram_slave_ram.md
Name: avalon_mm_sdram_slave_ram

Overview:
- Avalon-MM burst slave that terminates the SDRAM-style master port with on-chip RAM.
- Stands in for the external SDRAM controller in simulation and in FPGA bring-up builds, so DMA/packet masters can run without SDRAM.
- Accepts burst writes with byte enables and burst reads.
- Returns read data in order, one beat per cycle, flagged by readdata_val.

Parameters:
- ADDR_WIDTH, 32, width of the word address port.
- DATA_WIDTH, 64, data bus width in bits.
- BURST_COUNT_WIDTH, 8, width of burst_count.
- BYTE_ENABLE_WIDTH, DATA_WIDTH/8, byte enable width.
- MEM_ADDR_WIDTH, 10, log2 of RAM depth in words; must be <= ADDR_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset.
- address  in  ADDR_WIDTH  word address, sampled on the first beat of a command.
- burst_count  in  BURST_COUNT_WIDTH  beats in the burst, sampled on the first beat.
- write_data  in  DATA_WIDTH  write beat data.
- byte_enable  in  BYTE_ENABLE_WIDTH  per-byte write enable.
- write  in  1  write beat request.
- read  in  1  read command request.
- wait_request  out  1  slave stall.
- read_data  out  DATA_WIDTH  read beat data.
- readdata_val  out  1  read_data valid.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0.
- Reset values: wait_request=1, readdata_val=0, read_data=0, proto_err=0, state=IDLE. wait_request falls to 0 on the first clk edge after rst_n deasserts. RAM contents are not reset.
- Addressing: RAM index = address[MEM_ADDR_WIDTH-1:0]; upper bits are ignored (aliasing). The index increments by 1 per beat, modulo 2^MEM_ADDR_WIDTH (wraps 2^MEM_ADDR_WIDTH-1 -> 0 inside a burst).
- burst_count = 0: treated as 1, and proto_err is set.
- IDLE state: wait_request=0.
  - write=1, read=0: accept beat 0. Write the RAM at index with byte_enable. Latch index+1 and remaining = burst_count-1. If remaining=0, stay in IDLE; else go to WR.
  - read=1, write=0: accept the command, latch index and remaining = burst_count, go to RD.
  - read=1 and write=1: neither is accepted. wait_request is driven combinationally to 1 that cycle and proto_err is set.
- WR state: wait_request=0.
  - Each cycle with write=1 stores one beat at the current index, then increments the index and decrements remaining.
  - write=0 is a bubble: no change.
  - The last beat (remaining=1 at accept) returns to IDLE the next cycle.
  - address and burst_count are ignored in WR.
  - read=1 in WR sets proto_err and is ignored.
- RD state: wait_request=1.
  - One RAM read is issued per cycle at the current index.
  - The RAM has 1-cycle latency; read_data/readdata_val are registered at the output.
  - Command accepted at edge T: beats are valid at T+2 .. T+1+N, back-to-back, no gaps, in address order.
  - After the last RAM read is issued, go to IDLE. A new command may be accepted in the same cycle the final readdata_val beat is driven.
- readdata_val=0 outside burst data cycles; read_data holds its last value when readdata_val=0.
- Read-during-write: a read of a word written in an earlier cycle returns the new data. A same-cycle collision cannot occur, because RD and WR are exclusive.
- Reset mid-burst: state goes to IDLE, the remaining beats are dropped, readdata_val goes to 0 asynchronously, and RAM writes already done are kept.
- proto_err clears only on reset.

Decomposition:
- Package avalon_mm_sdram_pkg holds:
  - the state typedef (IDLE, WR, RD);
  - the localparam for read latency (2 cycles from accept to first beat).
- Sub-module avalon_mm_be_ram: single-clock simple dual-port RAM with per-byte write enable and registered 1-cycle read, parameterised by DATA_WIDTH and MEM_ADDR_WIDTH.
- The top module holds the FSM, index/remaining counters and output register.

Test Plan:
- Single write then read: write address=5, burst_count=1, data=64'h0123_4567_89AB_CDEF, byte_enable=8'hFF; then read address=5, burst_count=1 -> readdata_val high exactly 2 cycles after read accept, read_data=64'h0123_4567_89AB_CDEF; wait_request=1 for 1 cycle after accept.
- Burst with bubbles: write burst of 4 at address 1020 (MEM_ADDR_WIDTH=10) with write deasserted for 2 cycles between beats 1 and 2; read back burst of 4 -> data returned from indices 1020,1021,1022,1023 in order on 4 consecutive cycles. Then read address 1022, burst 4 -> last two beats come from indices 0,1 (wrap).
- Byte enables: write 64'hFFFF... then write 64'h0 with byte_enable=8'h0F at the same address -> readback 64'hFFFF_FFFF_0000_0000.
- Violations: read and write high together in IDLE -> wait_request=1 that cycle, no RAM change, proto_err=1. Separately, burst_count=0 read -> exactly 1 beat returned, proto_err=1.
- Reset mid-read: start a burst-16 read, pull rst_n low after 5 beats -> readdata_val=0 and wait_request=1 immediately. After release: wait_request=0 one edge later, proto_err=0, and a fresh read returns the previously written data.
